// File: rtl/disp_ref_window_gen.sv
`default_nettype none
// ============================================================================
// Module  : disp_ref_window_gen
// Purpose : Builds the vref/href active-region windows and a frame-start pulse
//           from raw display syncs. Define REF_POS_EN to add x_pos/y_pos.
// Revision: 1.0
// ============================================================================
module disp_ref_window_gen #(
  parameter int CW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vsync,
  input  logic          hsync,
  input  logic [CW-1:0] vref_p1,
  input  logic [CW-1:0] vref_p2,
  input  logic [CW-1:0] href_p1,
  input  logic [CW-1:0] href_p2,
  output logic          vref,
  output logic          href,
  output logic          vsync_start
`ifdef REF_POS_EN
  ,
  output logic [CW-1:0] x_pos,
  output logic [CW-1:0] y_pos
`endif
);

  localparam logic [CW-1:0] c_cnt_max = '1;

  logic          vs_dly_q, vs_dly_d;
  logic          hs_dly_q, hs_dly_d;
  logic [CW-1:0] hcnt_q, hcnt_d;
  logic [CW-1:0] vcnt_q, vcnt_d;
  logic          href_q, href_d;
  logic          vref_q, vref_d;
  logic          vsync_start_q, vsync_start_d;

  logic w_vs_rise, w_vs_fall, w_hs_rise, w_hs_fall;
  logic w_href_in, w_vref_in;

  always_comb begin
    w_vs_rise = vsync & ~vs_dly_q;
    w_vs_fall = ~vsync & vs_dly_q;
    w_hs_rise = hsync & ~hs_dly_q;
    w_hs_fall = ~hsync & hs_dly_q;
  end

  // Counters saturate rather than wrap so a stalled sync cannot re-open a window.
  always_comb begin
    vs_dly_d = vsync;
    hs_dly_d = hsync;

    hcnt_d = hcnt_q;
    if (w_hs_fall) begin
      hcnt_d = '0;
    end else if (hcnt_q != c_cnt_max) begin
      hcnt_d = hcnt_q + 1'b1;
    end

    vcnt_d = vcnt_q;
    if (w_vs_fall) begin
      vcnt_d = '0;
    end else if (w_hs_rise && (vcnt_q != c_cnt_max)) begin
      vcnt_d = vcnt_q + 1'b1;
    end
  end

  // An empty or inverted bound pair (p2 <= p1) makes the window condition unsatisfiable.
  always_comb begin
    w_href_in     = (hcnt_q >= href_p1) && (hcnt_q < href_p2);
    w_vref_in     = (vcnt_q >= vref_p1) && (vcnt_q < vref_p2);
    href_d        = w_href_in;
    vref_d        = w_vref_in;
    vsync_start_d = w_vs_rise;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_dly_q      <= 1'b0;
      hs_dly_q      <= 1'b0;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      href_q        <= 1'b0;
      vref_q        <= 1'b0;
      vsync_start_q <= 1'b0;
    end else begin
      vs_dly_q      <= vs_dly_d;
      hs_dly_q      <= hs_dly_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      href_q        <= href_d;
      vref_q        <= vref_d;
      vsync_start_q <= vsync_start_d;
    end
  end

  assign href        = href_q;
  assign vref        = vref_q;
  assign vsync_start = vsync_start_q;

`ifdef REF_POS_EN
  logic [CW-1:0] x_pos_q, x_pos_d;
  logic [CW-1:0] y_pos_q, y_pos_d;

  // Same compare stage as href/vref so positions line up with the window pixels.
  always_comb begin
    x_pos_d = '0;
    y_pos_d = '0;
    if (w_href_in) begin
      x_pos_d = hcnt_q - href_p1;
    end
    if (w_vref_in) begin
      y_pos_d = vcnt_q - vref_p1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_pos_q <= '0;
      y_pos_q <= '0;
    end else begin
      x_pos_q <= x_pos_d;
      y_pos_q <= y_pos_d;
    end
  end

  assign x_pos = x_pos_q;
  assign y_pos = y_pos_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_disp_ref_window_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_disp_ref_window_gen
// Purpose : Scoreboard bench for disp_ref_window_gen (default and REF_POS_EN).
// Revision: 1.0
// ============================================================================
module tb_disp_ref_window_gen;

  localparam int CW   = 12;
  localparam int MAXC = 4095;

  logic          clk = 1'b0;
  logic          rst;
  logic          vsync, hsync;
  logic [CW-1:0] vref_p1, vref_p2, href_p1, href_p2;
  logic          vref, href, vsync_start;
`ifdef REF_POS_EN
  logic [CW-1:0] x_pos, y_pos;
`endif

  always #5 clk = ~clk;

  disp_ref_window_gen #(.CW(CW)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .vsync       (vsync),
    .hsync       (hsync),
    .vref_p1     (vref_p1),
    .vref_p2     (vref_p2),
    .href_p1     (href_p1),
    .href_p2     (href_p2),
    .vref        (vref),
    .href        (href),
    .vsync_start (vsync_start)
`ifdef REF_POS_EN
    ,
    .x_pos       (x_pos),
    .y_pos       (y_pos)
`endif
  );

  // Scoreboard entry: counter values the DUT compares at a given edge.
  typedef struct {
    int   hc;
    int   vc;
    logic vst;
    bit   hvalid;
    bit   vvalid;
  } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  int m_hs, m_vs, m_hc, m_vc;
  bit m_hseen, m_vseen;

  int   step_idx = 0, fall_idx = 0, rise_off = 0;
  int   run_len = 0, last_run = 0, href_hi = 0;
  int   vrun_len = 0, vlast_run = 0, vref_hi = 0, vst_cnt = 0;
  int   x_first = -1, x_last = -1, y_first = -1, y_last = -1;
  logic p_href = 1'b0, p_vref = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic sample();
    exp_t e;
    int   eh, ev;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("vsync_start", {31'd0, vsync_start}, {31'd0, e.vst});
      eh = ((e.hc >= int'(href_p1)) && (e.hc < int'(href_p2))) ? 1 : 0;
      ev = ((e.vc >= int'(vref_p1)) && (e.vc < int'(vref_p2))) ? 1 : 0;
      if (e.hvalid) begin
        chk("href", {31'd0, href}, eh);
`ifdef REF_POS_EN
        chk("x_pos", {20'd0, x_pos}, (eh != 0) ? (e.hc - int'(href_p1)) : 0);
`endif
      end
      if (e.vvalid) begin
        chk("vref", {31'd0, vref}, ev);
`ifdef REF_POS_EN
        chk("y_pos", {20'd0, y_pos}, (ev != 0) ? (e.vc - int'(vref_p1)) : 0);
`endif
      end
    end
    if (href === 1'b1) begin
      if (p_href !== 1'b1) begin
        rise_off = step_idx - fall_idx;
`ifdef REF_POS_EN
        x_first = int'(x_pos);
`endif
      end
`ifdef REF_POS_EN
      x_last = int'(x_pos);
`endif
      run_len++;
      href_hi++;
    end else if (p_href === 1'b1) begin
      last_run = run_len;
      run_len  = 0;
    end
    if (vref === 1'b1) begin
`ifdef REF_POS_EN
      if (p_vref !== 1'b1) y_first = int'(y_pos);
      y_last = int'(y_pos);
`endif
      vrun_len++;
      vref_hi++;
    end else if (p_vref === 1'b1) begin
      vlast_run = vrun_len;
      vrun_len  = 0;
    end
    if (vsync_start === 1'b1) vst_cnt++;
    p_href = href;
    p_vref = vref;
  endtask

  // Predict the DUT counters at the coming edge, then advance the model.
  task automatic push(input logic vs_i, input logic hs_i);
    exp_t e;
    e.hc     = m_hc;
    e.vc     = m_vc;
    e.vst    = vs_i && (m_vs == 0);
    e.hvalid = m_hseen;
    e.vvalid = m_vseen;
    sb.push_back(e);
    if (!hs_i && m_hs != 0) begin
      m_hc = 0;
      m_hseen = 1'b1;
    end else if (m_hc < MAXC) begin
      m_hc++;
    end
    if (!vs_i && m_vs != 0) begin
      m_vc = 0;
      m_vseen = 1'b1;
    end else if (hs_i && m_hs == 0 && m_vc < MAXC) begin
      m_vc++;
    end
    m_hs = hs_i ? 1 : 0;
    m_vs = vs_i ? 1 : 0;
  endtask

  task automatic step(input logic vs_i, input logic hs_i);
    @(negedge clk);
    sample();
    if (hsync === 1'b1 && !hs_i) fall_idx = step_idx;
    vsync = vs_i;
    hsync = hs_i;
    push(vs_i, hs_i);
    step_idx++;
  endtask

  task automatic gen_line(input int len, input int hsw, input logic vs_i);
    for (int i = 0; i < len; i++) step(vs_i, (i < hsw));
  endtask

  // Reset is raised between edges to exercise the asynchronous clear.
  task automatic apply_reset(input int ncyc);
    @(negedge clk);
    sample();
    #2 rst = 1'b1;
    sb.delete();
    m_hs = 0; m_vs = 0; m_hc = 0; m_vc = 0;
    m_hseen = 1'b0; m_vseen = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      chk("rst_href", {31'd0, href}, 0);
      chk("rst_vref", {31'd0, vref}, 0);
      chk("rst_vsync_start", {31'd0, vsync_start}, 0);
`ifdef REF_POS_EN
      chk("rst_x_pos", {20'd0, x_pos}, 0);
      chk("rst_y_pos", {20'd0, y_pos}, 0);
`endif
    end
    rst = 1'b0;
    push(vsync, hsync);
    p_href = 1'b0; p_vref = 1'b0;
    run_len = 0; vrun_len = 0;
  endtask

  task automatic check_hline(input string tag);
    chk({tag, "_href_width"}, last_run, 1920);
    chk({tag, "_href_rise"}, rise_off, 150);
`ifdef REF_POS_EN
    chk({tag, "_x_first"}, x_first, 0);
    chk({tag, "_x_last"}, x_last, 1919);
`endif
  endtask

  initial begin
    rst = 1'b1;
    vsync = 1'b0;
    hsync = 1'b0;
    vref_p1 = 12'd37;  vref_p2 = 12'd1117;
    href_p1 = 12'd148; href_p2 = 12'd2068;
    apply_reset(20);

    // 1080p lines: 2200 clocks, 44-clock hsync
    for (int l = 0; l < 3; l++) begin
      last_run = 0; rise_off = 0;
      gen_line(2200, 44, 1'b0);
      check_hline("h1080");
    end

    // Mid-line reset for 200 ns, then resync on the next lines
    gen_line(1000, 44, 1'b0);
    apply_reset(20);
    for (int l = 0; l < 2; l++) begin
      last_run = 0; rise_off = 0;
      gen_line(2200, 44, 1'b0);
      check_hline("post_rst");
    end

    // Vertical: 1125 short lines, 5-line vsync
    href_p1 = 12'd5; href_p2 = 12'd15;
    vst_cnt = 0; vlast_run = 0; y_first = -1; y_last = -1;
    for (int l = 0; l < 1125; l++) gen_line(20, 4, (l < 5));
    chk("vsync_start_per_frame", vst_cnt, 1);
    chk("vref_frame_cycles", vlast_run, 1080 * 20);
`ifdef REF_POS_EN
    chk("y_first", y_first, 0);
    chk("y_last", y_last, 1079);
`endif
    for (int l = 0; l < 7; l++) gen_line(20, 4, (l < 5));
    chk("vsync_start_two_frames", vst_cnt, 2);

    // Empty / inverted windows
    href_p1 = 12'd500; href_p2 = 12'd500;
    vref_p1 = 12'd40;  vref_p2 = 12'd10;
    gen_line(600, 10, 1'b1);
    href_hi = 0; vref_hi = 0;
    for (int l = 0; l < 3; l++) gen_line(600, 10, 1'b0);
    for (int l = 0; l < 60; l++) gen_line(30, 4, 1'b0);
    chk("empty_href", href_hi, 0);
    chk("empty_vref", vref_hi, 0);

    // Pixel counter saturation
    href_p1 = 12'd4000; href_p2 = 12'd4095;
    gen_line(20, 4, 1'b0);
    href_hi = 0; last_run = 0;
    gen_line(4300, 10, 1'b0);
    chk("sat_href_width", last_run, 95);
    chk("sat_href_total", href_hi, 95);
    step(1'b0, 1'b0);
    chk("sat_href_low", {31'd0, href}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
